laser_cover_check: RTL

Downstream checker for the two-laser placement engine. It captures the same 40-point (X,Y) stream the engine receives and waits for the engine's DONE pulse. It then latches C1/C2 and walks the stored points one per cycle, counting the points covered by each circle and by their union. The result supports on-chip self-check and scoring of each pattern before the next pattern starts.

---
 rtl/laser_pkg.sv | 39 +++
 rtl/laser_dist_chk.sv | 33 +++
 rtl/laser_cover_check.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/laser_pkg.sv
// laser_pkg
// Shared constants, state encoding, point record and the absolute-difference
// helper used by the laser coverage checker.
package laser_pkg;

    localparam int NPTS      = 40;         // points per pattern
    localparam int CW        = 4;          // coordinate width (grid 0..15)
    localparam int RADIUS_SQ = 16;         // squared coverage radius (inclusive)
    localparam int IDX_W     = 6;          // enough to index NPTS entries
    localparam int CNT_W     = 6;          // enough to hold a count of NPTS
    localparam int DIST_W    = 2 * CW + 1; // holds dx*dx+dy*dy (max 450)

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WAIT   = 2'd1,
        CHECK  = 2'd2,
        REPORT = 2'd3
    } state_e;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } point_t;

    // |a - b| without a sign bit; saturates naturally at 2**CW-1.
    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a,
                                               input logic [CW-1:0] b);
        logic [CW-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/laser_dist_chk.sv
// laser_dist_chk
// Combinational coverage test of one point against one circle centre.
// Ports:
//   px, py    : point coordinates
//   cx, cy    : circle centre coordinates
//   in_range  : 1 when dx*dx + dy*dy <= RADIUS_SQ (boundary is covered)
module laser_dist_chk
    import laser_pkg::*;
(
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] py,
    input  logic [CW-1:0] cx,
    input  logic [CW-1:0] cy,
    output logic          in_range
);

    logic [CW-1:0]     dx_s;
    logic [CW-1:0]     dy_s;
    logic [DIST_W-1:0] dx_w_s;
    logic [DIST_W-1:0] dy_w_s;
    logic [DIST_W-1:0] dist_sq_s;

    // Squared Euclidean distance, widened before multiplying so nothing overflows.
    always_comb begin
        dx_s      = abs_diff(px, cx);
        dy_s      = abs_diff(py, cy);
        dx_w_s    = DIST_W'(dx_s);
        dy_w_s    = DIST_W'(dy_s);
        dist_sq_s = (dx_w_s * dx_w_s) + (dy_w_s * dy_w_s);
        in_range  = (dist_sq_s <= DIST_W'(RADIUS_SQ));
    end

endmodule

// File: rtl/laser_cover_check.sv
// laser_cover_check
// Captures a NPTS-point pattern, waits for the placement engine's DONE pulse,
// then walks the stored points one per cycle counting coverage by C1, C2 and
// their union, and reports the counts with a one-cycle OUT_VALID pulse.
// Ports:
//   CLK, RST_N                : clock, synchronous active-low reset
//   IN_VALID, X, Y            : point stream
//   DONE_IN, C1X/C1Y/C2X/C2Y  : engine done pulse and circle centres
//   BUSY                      : high while waiting for DONE or checking
//   OUT_VALID                 : one-cycle pulse, counts valid
//   COVER_CNT, C1_CNT, C2_CNT : union / C1 / C2 coverage counts (held)
//   PROTO_ERR                 : sticky, DONE_IN seen while still loading
module laser_cover_check
    import laser_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    input  logic          DONE_IN,
    input  logic [CW-1:0] C1X,
    input  logic [CW-1:0] C1Y,
    input  logic [CW-1:0] C2X,
    input  logic [CW-1:0] C2Y,
    output logic          BUSY,
    output logic          OUT_VALID,
    output logic [5:0]    COVER_CNT,
    output logic [5:0]    C1_CNT,
    output logic [5:0]    C2_CNT,
    output logic          PROTO_ERR
);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    point_t             mem_q [NPTS];
    point_t             mem_d [NPTS];
    point_t             c1_q,        c1_d;
    point_t             c2_q,        c2_d;
    logic [CNT_W-1:0]   c1_acc_q,    c1_acc_d;
    logic [CNT_W-1:0]   c2_acc_q,    c2_acc_d;
    logic [CNT_W-1:0]   cov_acc_q,   cov_acc_d;
    logic               busy_q,      busy_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   cover_cnt_q, cover_cnt_d;
    logic [CNT_W-1:0]   c1_cnt_q,    c1_cnt_d;
    logic [CNT_W-1:0]   c2_cnt_q,    c2_cnt_d;
    logic               proto_err_q, proto_err_d;

    point_t             cur_pt_s;
    logic               in1_s;
    logic               in2_s;

    // Point under test during CHECK.
    always_comb begin
        cur_pt_s = mem_q[idx_q];
    end

    laser_dist_chk u_chk_c1 (
        .px       (cur_pt_s.x),
        .py       (cur_pt_s.y),
        .cx       (c1_q.x),
        .cy       (c1_q.y),
        .in_range (in1_s)
    );

    laser_dist_chk u_chk_c2 (
        .px       (cur_pt_s.x),
        .py       (cur_pt_s.y),
        .cx       (c2_q.x),
        .cy       (c2_q.y),
        .in_range (in2_s)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mem_d       = mem_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        c1_acc_d    = c1_acc_q;
        c2_acc_d    = c2_acc_q;
        cov_acc_d   = cov_acc_q;
        out_valid_d = 1'b0;
        cover_cnt_d = cover_cnt_q;
        c1_cnt_d    = c1_cnt_q;
        c2_cnt_d    = c2_cnt_q;
        proto_err_d = proto_err_q;

        case (state_q)
            LOAD: begin
                if (IN_VALID) begin
                    mem_d[idx_q] = '{x: X, y: Y};
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = WAIT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
                // The engine must not finish before the pattern is complete.
                if (DONE_IN) begin
                    proto_err_d = 1'b1;
                end else begin
                    proto_err_d = proto_err_q;
                end
            end
            WAIT: begin
                if (DONE_IN) begin
                    c1_d      = '{x: C1X, y: C1Y};
                    c2_d      = '{x: C2X, y: C2Y};
                    c1_acc_d  = '0;
                    c2_acc_d  = '0;
                    cov_acc_d = '0;
                    idx_d     = '0;
                    state_d   = CHECK;
                end else begin
                    state_d   = WAIT;
                end
            end
            CHECK: begin
                c1_acc_d  = c1_acc_q  + {{(CNT_W-1){1'b0}}, in1_s};
                c2_acc_d  = c2_acc_q  + {{(CNT_W-1){1'b0}}, in2_s};
                cov_acc_d = cov_acc_q + {{(CNT_W-1){1'b0}}, (in1_s | in2_s)};
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = REPORT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            REPORT: begin
                // Counts become visible together with OUT_VALID on the next edge.
                cover_cnt_d = cov_acc_q;
                c1_cnt_d    = c1_acc_q;
                c2_cnt_d    = c2_acc_q;
                out_valid_d = 1'b1;
                idx_d       = '0;
                state_d     = LOAD;
            end
            default: begin
                idx_d   = '0;
                state_d = LOAD;
            end
        endcase

        busy_d = (state_d == WAIT) || (state_d == CHECK);
    end

    // State, memory and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            mem_q       <= '{default: '0};
            c1_q        <= '0;
            c2_q        <= '0;
            c1_acc_q    <= '0;
            c2_acc_q    <= '0;
            cov_acc_q   <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cover_cnt_q <= '0;
            c1_cnt_q    <= '0;
            c2_cnt_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mem_q       <= mem_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            c1_acc_q    <= c1_acc_d;
            c2_acc_q    <= c2_acc_d;
            cov_acc_q   <= cov_acc_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            cover_cnt_q <= cover_cnt_d;
            c1_cnt_q    <= c1_cnt_d;
            c2_cnt_q    <= c2_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign BUSY      = busy_q;
    assign OUT_VALID = out_valid_q;
    assign COVER_CNT = cover_cnt_q;
    assign C1_CNT    = c1_cnt_q;
    assign C2_CNT    = c2_cnt_q;
    assign PROTO_ERR = proto_err_q;

endmodule
